// File: rtl/frame_dump_streamer_if.sv
// Read-port and UART-side signals of the frame dump streamer.
// The master modport is the streamer; the slave modport is the buffer plus the UART.
interface frame_dump_streamer_if #(
    parameter int X_BITS     = 6,
    parameter int Y_BITS     = 5,
    parameter int WORD_BYTES = 4
);
    logic [X_BITS-1:0]       read_x;
    logic [Y_BITS-1:0]       read_y;
    logic [8*WORD_BYTES-1:0] read_q;
    logic                    uart_busy;
    logic                    uart_write;
    logic [7:0]              uart_data;

    modport master (
        output read_x, read_y, uart_write, uart_data,
        input  read_q, uart_busy
    );

    modport slave (
        input  read_x, read_y, uart_write, uart_data,
        output read_q, uart_busy
    );
endinterface

// File: rtl/frame_dump_streamer.sv
// Walks a synchronous-read frame buffer and streams each word MSB byte first to a UART,
// optionally preceded by a sync header and the running frame counter.
module frame_dump_streamer #(
    parameter int          X_COUNT      = 40,
    parameter int          Y_COUNT      = 30,
    parameter int          X_BITS       = 6,
    parameter int          Y_BITS       = 5,
    parameter int          WORD_BYTES   = 4,
    parameter int          HOLDOFF_BITS = 13,
    parameter int          HEADER_EN    = 1,
    parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
    input  logic                 clock,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 continuous,
    frame_dump_streamer_if.master bus,
    output logic                 active,
    output logic [7:0]           frame_count
);
    localparam int W = 8 * WORD_BYTES;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_LOAD, S_SEND, S_EOF} state_t;

    localparam state_t FIRST_ST = (HEADER_EN != 0) ? S_HDR : S_FETCH;

    state_t                  state_q, state_d;
    logic [X_BITS-1:0]       x_q, x_d;
    logic [Y_BITS-1:0]       y_q, y_d;
    logic                    wr_q, wr_d;
    logic [7:0]              data_q, data_d;
    logic [7:0]              fc_q, fc_d;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic [3:0]              idx_q, idx_d;
    logic                    last_q, last_d;
    logic [W-1:0]            sh_q;
    logic                    load, shift, send_ok;

    // A strobe needs a full quiet gap on the UART and never follows another strobe directly.
    assign send_ok = (&hold_q) && !bus.uart_busy && !wr_q;

    always_comb begin
        if (bus.uart_busy)  hold_d = '0;
        else if (&hold_q)   hold_d = hold_q;
        else                hold_d = hold_q + HOLDOFF_BITS'(1);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        fc_d    = fc_q;
        idx_d   = idx_q;
        last_d  = last_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    idx_d   = '0;
                    state_d = FIRST_ST;
                end
            end
            S_HDR: begin
                if (send_ok) begin
                    wr_d = 1'b1;
                    case (idx_q[1:0])
                        2'd0:    data_d = SYNC_WORD[15:8];
                        2'd1:    data_d = SYNC_WORD[7:0];
                        default: data_d = fc_q;
                    endcase
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd2) state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                load   = 1'b1;
                idx_d  = '0;
                last_d = (x_q == X_BITS'(X_COUNT - 1)) && (y_q == Y_BITS'(Y_COUNT - 1));
                // Addressing runs one word ahead so the next fetch needs no extra cycle.
                if (x_q == X_BITS'(X_COUNT - 1)) begin
                    x_d = '0;
                    y_d = y_q + Y_BITS'(1);
                end else begin
                    x_d = x_q + X_BITS'(1);
                end
                state_d = S_SEND;
            end
            S_SEND: begin
                if (send_ok) begin
                    wr_d   = 1'b1;
                    data_d = sh_q[W-1 -: 8];
                    shift  = 1'b1;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == 4'(WORD_BYTES - 1)) state_d = last_q ? S_EOF : S_FETCH;
                end
            end
            S_EOF: begin
                fc_d    = fc_q + 8'd1;
                x_d     = '0;
                y_d     = '0;
                idx_d   = '0;
                state_d = continuous ? FIRST_ST : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            fc_q    <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            fc_q    <= fc_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // The word shifter carries only data and is always loaded before use.
    always_ff @(posedge clock) begin
        if (load)       sh_q <= bus.read_q;
        else if (shift) sh_q <= sh_q << 8;
    end

    assign bus.read_x     = x_q;
    assign bus.read_y     = y_q;
    assign bus.uart_write = wr_q;
    assign bus.uart_data  = data_q;
    assign active         = (state_q != S_IDLE);
    assign frame_count    = fc_q;
endmodule
